spi_pkt_deframer: RTL

//   Drains the byte FIFO filled by the SPI receive path and splits the stream into frames:
//   SOF, LEN, LEN payload bytes, then a checksum byte. Runs in the axi_aclk domain.

---
 rtl/spi_pkt_deframer_if.sv | 21 ++
 rtl/spi_pkt_deframer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/spi_pkt_deframer_if.sv
// FIFO-drain and payload-stream signals of the SPI packet deframer.
// master = deframer side, slave = FIFO/downstream side.
interface spi_pkt_deframer_if;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/spi_pkt_deframer.sv
// Splits the SPI byte FIFO into SOF/LEN/payload/checksum frames; one byte in flight, 1 byte per 3 cycles.
// Payload stalls on m_ready (holding the byte and fetch); backpressure freezes the timeout.
module spi_pkt_deframer #(
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic               axi_aclk,
  input  logic               axi_areset,
  spi_pkt_deframer_if.master io,
  output logic [7:0]         pkt_len,
  output logic               package_start_int,
  output logic               package_end_int,
  output logic               package_err_int
);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q;
  logic        hold_valid;
  logic        rd_pending;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  len_q, len_d;
  logic [15:0] idle_q, idle_d;
  logic        consume;
  logic        stall;

  assign io.fifo_rd_en = !io.fifo_empty && !rd_pending && !hold_valid && !axi_areset;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q    <= IDLE;
      byte_q     <= 8'd0;
      hold_valid <= 1'b0;
      rd_pending <= 1'b0;
      sum_q      <= 8'd0;
      rem_q      <= 8'd0;
      len_q      <= 8'd0;
      idle_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      idle_q     <= idle_d;
      rd_pending <= io.fifo_rd_en;
      // rd_pending and hold_valid are never both set, so load and consume cannot collide
      if (rd_pending) begin
        byte_q     <= io.fifo_rd_data;
        hold_valid <= 1'b1;
      end else if (consume) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    sum_d             = sum_q;
    rem_d             = rem_q;
    len_d             = len_q;
    idle_d            = idle_q;
    package_start_int = 1'b0;
    package_end_int   = 1'b0;
    package_err_int   = 1'b0;
    io.m_valid        = 1'b0;
    io.m_last         = 1'b0;
    io.m_data         = byte_q;
    pkt_len           = len_q;

    stall   = (state_q == PAYLOAD) && hold_valid && !io.m_ready;
    consume = hold_valid && ((state_q != PAYLOAD) || io.m_ready);

    if (state_q == PAYLOAD) begin
      io.m_valid = hold_valid;
      io.m_last  = (rem_q == 8'd1);
    end

    if (consume) begin
      idle_d = 16'd0;
      case (state_q)
        IDLE: begin
          if (byte_q == SOF_BYTE) begin
            state_d           = LEN;
            package_start_int = 1'b1;
          end
        end
        LEN: begin
          len_d   = byte_q;
          sum_d   = byte_q;
          rem_d   = byte_q;
          state_d = (byte_q == 8'd0) ? CSUM : PAYLOAD;
        end
        PAYLOAD: begin
          sum_d = sum_q + byte_q;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = CSUM;
        end
        CSUM: begin
          if (byte_q == sum_q) package_end_int = 1'b1;
          else                 package_err_int = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      idle_d = 16'd0;
    end else if (!stall) begin
      if (idle_q == TIMEOUT_CYC - 16'd1) begin
        package_err_int = 1'b1;
        state_d         = IDLE;
        idle_d          = 16'd0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end

    // Reset silences every output, even while registers still hold pre-reset state
    if (axi_areset) begin
      package_start_int = 1'b0;
      package_end_int   = 1'b0;
      package_err_int   = 1'b0;
      io.m_valid        = 1'b0;
      io.m_last         = 1'b0;
      io.m_data         = 8'd0;
      pkt_len           = 8'd0;
    end
  end

endmodule
